// File: rtl/project1_pkg.sv
// Shared constants for the result display: active-low segment
// patterns ({g,f,e,d,c,b,a}) and the display FSM state encoding.
package project1_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } disp_state_t;

endpackage

// File: rtl/seg7_encode.sv
// BCD digit to active-low 7-segment pattern; blank_n=0 or
// a non-decimal nibble gives a dark digit.
module seg7_encode
  import project1_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank_n,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (blank_n) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/result_display.sv
// Sequential binary-to-BCD (shift-add-3) of the ALU result with an
// atomic, flicker-free update of four 7-segment digits.
module result_display
  import project1_pkg::*;
#(
  parameter int width = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2*width-1:0] value,
  input  logic              err,
  output logic [6:0]        seg_4,
  output logic [6:0]        seg_3,
  output logic [6:0]        seg_2,
  output logic [6:0]        seg_1,
  output logic              busy,
  output logic              done
);

  localparam int VW = 2 * width;

  if (VW > 13) begin : g_width_check
    $error("result_display: 2*width must be <= 13");
  end

  disp_state_t      state, state_n;
  logic             pending;
  logic [VW-1:0]    snap_val;
  logic             snap_err;
  logic [VW-1:0]    sh;
  logic [15:0]      bcd;
  logic [15:0]      bcd_adj;
  logic [3:0]       cnt;
  logic             changed;
  logic [6:0]       enc_4, enc_3, enc_2, enc_1;

  assign changed = pending || (value != snap_val) || (err != snap_err);
  assign busy    = (state != IDLE);

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (changed) state_n = SHIFT;
      SHIFT:   if (cnt == 4'(VW - 1)) state_n = LATCH;
      LATCH:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Leading-zero blanking: a digit lights if it or any higher digit is nonzero.
  seg7_encode u_enc_4 (
    .bcd     (bcd[15:12]),
    .blank_n (|bcd[15:12]),
    .seg     (enc_4)
  );

  seg7_encode u_enc_3 (
    .bcd     (bcd[11:8]),
    .blank_n (|bcd[15:8]),
    .seg     (enc_3)
  );

  seg7_encode u_enc_2 (
    .bcd     (bcd[7:4]),
    .blank_n (|bcd[15:4]),
    .seg     (enc_2)
  );

  seg7_encode u_enc_1 (
    .bcd     (bcd[3:0]),
    .blank_n (1'b1),
    .seg     (enc_1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_4    <= SEG_BLANK;
      seg_3    <= SEG_BLANK;
      seg_2    <= SEG_BLANK;
      seg_1    <= SEG_BLANK;
      done     <= 1'b0;
      pending  <= 1'b1;
      cnt      <= '0;
      sh       <= '0;
      bcd      <= '0;
      snap_val <= '0;
      snap_err <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (changed) begin
            snap_val <= value;
            snap_err <= err;
            sh       <= value;
            bcd      <= '0;
            cnt      <= '0;
            pending  <= 1'b0;
          end
        end
        SHIFT: begin
          bcd <= {bcd_adj[14:0], sh[VW-1]};
          sh  <= sh << 1;
          cnt <= cnt + 4'd1;
        end
        LATCH: begin
          done <= 1'b1;
          if (snap_err) begin
            seg_4 <= SEG_BLANK;
            seg_3 <= SEG_E;
            seg_2 <= SEG_R;
            seg_1 <= SEG_R;
          end else begin
            seg_4 <= enc_4;
            seg_3 <= enc_3;
            seg_2 <= enc_2;
            seg_1 <= enc_1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display: expected displays are queued at
// stimulus time and compared whenever done pulses.
module tb_result_display;

  localparam int W = 6;

  typedef struct packed {
    logic [6:0] s4;
    logic [6:0] s3;
    logic [6:0] s2;
    logic [6:0] s1;
  } disp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [2*W-1:0] value;
  logic           err;
  logic [6:0]     seg_4, seg_3, seg_2, seg_1;
  logic           busy, done;

  int vectors = 0;
  int miscompares = 0;
  disp_t sb[$];

  result_display #(.width(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .err   (err),
    .seg_4 (seg_4),
    .seg_3 (seg_3),
    .seg_2 (seg_2),
    .seg_1 (seg_1),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges after the current point until done is seen (bounded).
  task automatic wait_done(input string tag, input int exp_n);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 40);
    chk({tag, "_latency"}, n, exp_n);
  endtask

  // Next edge is the capture edge; expect done 13 edges later.
  task automatic run_conv(input string tag);
    int n = 0;
    int nb;
    tick();
    nb = busy ? 1 : 0;
    do begin
      tick();
      n++;
      if (!done && busy) nb++;
    end while (!done && n < 40);
    chk({tag, "_latency"}, n, 13);
    chk({tag, "_busy_cycles"}, nb, 13);
    chk({tag, "_busy_after"}, busy, 1'b0);
    tick();
    chk({tag, "_done_width"}, done, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      vectors++;
      assert (sb.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_done observed=done expected=no_done");
      end
      if (sb.size() > 0) begin
        disp_t e;
        e = sb.pop_front();
        vectors++;
        assert ({seg_4, seg_3, seg_2, seg_1} === e) else begin
          miscompares++;
          $error("FAIL display observed=%h %h %h %h expected=%h %h %h %h",
                 seg_4, seg_3, seg_2, seg_1, e.s4, e.s3, e.s2, e.s1);
        end
      end
    end
  end

  initial begin
    int idle_busy;
    rst   = 1'b1;
    value = '0;
    err   = 1'b0;
    repeat (2) tick();
    chk("rst_seg4", seg_4, 7'h7F);
    chk("rst_seg3", seg_3, 7'h7F);
    chk("rst_seg2", seg_2, 7'h7F);
    chk("rst_seg1", seg_1, 7'h7F);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    rst = 1'b0;
    sb.push_back('{7'h7F, 7'h7F, 7'h7F, 7'h40});
    run_conv("zero");

    value = 12'd4095;
    sb.push_back('{7'h19, 7'h40, 7'h10, 7'h12});
    run_conv("v4095");

    value = 12'd7;
    sb.push_back('{7'h7F, 7'h7F, 7'h7F, 7'h78});
    run_conv("v7");

    value = 12'd100;
    sb.push_back('{7'h7F, 7'h79, 7'h40, 7'h40});
    run_conv("v100");

    value = 12'd55;
    err   = 1'b1;
    sb.push_back('{7'h7F, 7'h06, 7'h2F, 7'h2F});
    run_conv("err55");

    err = 1'b0;
    sb.push_back('{7'h7F, 7'h7F, 7'h12, 7'h12});
    run_conv("v55");

    // Change the input three cycles into SHIFT.
    value = 12'd100;
    sb.push_back('{7'h7F, 7'h79, 7'h40, 7'h40});
    tick();
    chk("mid_busy", busy, 1'b1);
    repeat (3) tick();
    value = 12'd2500;
    sb.push_back('{7'h24, 7'h12, 7'h40, 7'h40});
    wait_done("mid_first", 10);
    wait_done("mid_second", 14);

    // Reset during SHIFT blanks and restarts with the held value.
    value = 12'd1234;
    sb.push_back('{7'h79, 7'h24, 7'h30, 7'h19});
    tick();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("abort_seg4", seg_4, 7'h7F);
    chk("abort_seg3", seg_3, 7'h7F);
    chk("abort_seg2", seg_2, 7'h7F);
    chk("abort_seg1", seg_1, 7'h7F);
    chk("abort_busy", busy, 1'b0);
    rst = 1'b0;
    run_conv("restart");

    idle_busy = 0;
    repeat (20) begin
      tick();
      if (busy) idle_busy++;
    end
    chk("idle_busy", idle_busy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
